// File: rtl/id_issue.sv
// Registered decode/issue stage: RV32I/M/Zicsr decode, forwarding, load-use scoreboard.
// Optional: define ID_ILLEGAL_INST_EN to flag illegal instructions in out_exception_o[2].
module id_issue #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [31:0]                inst_i,
    input  logic [XLEN-1:0]            inst_addr_i,
    output logic [RADDR_W-1:0]         reg1_raddr_o,
    output logic [RADDR_W-1:0]         reg2_raddr_o,
    input  logic [XLEN-1:0]            reg1_rdata_i,
    input  logic [XLEN-1:0]            reg2_rdata_i,
    input  logic [NUM_FWD-1:0]         fwd_we_i,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*XLEN-1:0]    fwd_wdata_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                out_inst_o,
    output logic [XLEN-1:0]            out_inst_addr_o,
    output logic [XLEN-1:0]            out_op1_o,
    output logic [XLEN-1:0]            out_op2_o,
    output logic                       out_reg_we_o,
    output logic [RADDR_W-1:0]         out_reg_waddr_o,
    output logic                       out_is_load_o,
    output logic                       out_csr_we_o,
    output logic [11:0]                out_csr_addr_o,
    output logic [31:0]                out_exception_o
);
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int          NREG = 1 << RADDR_W;
    localparam logic [2:0]  LAT  = 3'(LOAD_LAT);
`ifdef ID_ILLEGAL_INST_EN
    localparam logic ILL_FLAG = 1'b1;
`else
    localparam logic ILL_FLAG = 1'b0;
`endif

    typedef enum logic [6:0] {
        OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL    = 7'b1101111,
        OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
        OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG    = 7'b0110011,
        OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic               valid;
        logic [31:0]        inst;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic               reg_we;
        logic [RADDR_W-1:0] rd;
        logic               is_load;
        logic               csr_we;
        logic [11:0]        csr_addr;
        logic [2:0]         exc;   // {illegal, ecall, mret}
    } issue_t;

    // Forwarded operand: x0 reads zero, lowest-index matching source wins, else regfile.
    function automatic logic [XLEN-1:0] read_src(
        input logic [RADDR_W-1:0]         addr,
        input logic [XLEN-1:0]            rf_data,
        input logic [NUM_FWD-1:0]         we,
        input logic [NUM_FWD*RADDR_W-1:0] waddr,
        input logic [NUM_FWD*XLEN-1:0]    wdata
    );
        logic [XLEN-1:0] val;
        val = rf_data;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (we[k] && waddr[k*RADDR_W +: RADDR_W] == addr) val = wdata[k*XLEN +: XLEN];
        end
        if (addr == '0) val = '0;
        return val;
    endfunction

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [RADDR_W-1:0] rs1, rs2;
    logic [XLEN-1:0]    rs1_val, rs2_val, imm_i, imm_u, uimm;
    logic               rs1_en, rs2_en, illegal, hazard, accept;
    issue_t             dec, out_d, out_q;
    logic [2:0]         cnt_d [NREG];
    logic [2:0]         cnt_q [NREG];

    assign opcode  = inst_i[6:0];
    assign funct3  = inst_i[14:12];
    assign rs1     = inst_i[15 +: RADDR_W];
    assign rs2     = inst_i[20 +: RADDR_W];
    assign imm_i   = XLEN'($signed(inst_i[31:20]));
    assign imm_u   = XLEN'({inst_i[31:12], 12'b0});
    assign uimm    = XLEN'(inst_i[19:15]);
    assign rs1_val = read_src(rs1, reg1_rdata_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i);
    assign rs2_val = read_src(rs2, reg2_rdata_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i);

    assign reg1_raddr_o = rs1;
    assign reg2_raddr_o = rs2;

    always_comb begin
        // NOTE: every field gets a default up front so no path through the case infers a latch.
        dec          = '0;
        dec.valid    = 1'b1;
        dec.inst     = inst_i;
        dec.pc       = inst_addr_i;
        dec.rd       = inst_i[7 +: RADDR_W];
        dec.csr_addr = inst_i[31:20];
        rs1_en       = 1'b0;
        rs2_en       = 1'b0;
        illegal      = 1'b0;
        case (opcode)
            OP_LUI:    begin dec.reg_we = 1'b1; dec.op1 = imm_u; end
            OP_AUIPC:  begin dec.reg_we = 1'b1; dec.op1 = inst_addr_i; dec.op2 = imm_u; end
            OP_JAL:    begin dec.reg_we = 1'b1; dec.op1 = inst_addr_i; dec.op2 = XLEN'(4); end
            OP_JALR:   begin rs1_en = 1'b1; dec.reg_we = 1'b1; dec.op1 = rs1_val; dec.op2 = imm_i; end
            OP_BRANCH, OP_STORE: begin
                rs1_en  = 1'b1;
                rs2_en  = 1'b1;
                dec.op1 = rs1_val;
                dec.op2 = rs2_val;
            end
            OP_LOAD: begin
                rs1_en      = 1'b1;
                dec.reg_we  = 1'b1;
                dec.is_load = 1'b1;
                dec.op1     = rs1_val;
                dec.op2     = imm_i;
            end
            OP_IMM:    begin rs1_en = 1'b1; dec.reg_we = 1'b1; dec.op1 = rs1_val; dec.op2 = imm_i; end
            OP_REG: begin
                rs1_en     = 1'b1;
                rs2_en     = 1'b1;
                dec.reg_we = 1'b1;
                dec.op1    = rs1_val;
                dec.op2    = rs2_val;
            end
            OP_FENCE:  ;
            OP_SYSTEM: begin
                case (funct3)
                    3'b000: begin
                        if (inst_i == 32'h3020_0073)      dec.exc[0] = 1'b1;
                        else if (inst_i == 32'h0000_0073) dec.exc[1] = 1'b1;
                        else                              illegal    = 1'b1;
                    end
                    3'b001, 3'b010, 3'b011: begin
                        rs1_en     = 1'b1;
                        dec.reg_we = 1'b1;
                        dec.csr_we = 1'b1;
                        dec.op1    = rs1_val;
                    end
                    3'b101, 3'b110, 3'b111: begin
                        dec.reg_we = 1'b1;
                        dec.csr_we = 1'b1;
                        dec.op1    = uimm;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default:   illegal = 1'b1;
        endcase
        if (illegal) begin
            dec        = '0;
            dec.valid  = 1'b1;
            dec.inst   = NOP;
            dec.pc     = inst_addr_i;
            dec.exc[2] = ILL_FLAG;
            rs1_en     = 1'b0;
            rs2_en     = 1'b0;
        end
    end

    assign hazard = (rs1_en && rs1 != '0 && cnt_q[rs1] != '0)
                 || (rs2_en && rs2 != '0 && cnt_q[rs2] != '0);
    assign in_ready_o = !flush_i && !hazard && (!out_q.valid || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        out_d = out_q;
        if (flush_i || (!accept && out_ready_i)) begin
            out_d.valid   = 1'b0;
            out_d.inst    = NOP;
            out_d.reg_we  = 1'b0;
            out_d.is_load = 1'b0;
            out_d.csr_we  = 1'b0;
            out_d.exc     = '0;
        end else if (accept) begin
            out_d = dec;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush_i)
                cnt_d[r] = '0;
            else if (accept && dec.is_load && dec.rd == RADDR_W'(r))
                cnt_d[r] = LAT;
            else if (out_ready_i && cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - 3'd1;
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q      <= '0;
            out_q.inst <= NOP;
            // NOTE: the scoreboard is a flop array, so it clears with the reset like any other state.
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            out_q <= out_d;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign out_valid_o     = out_q.valid;
    assign out_inst_o      = out_q.inst;
    assign out_inst_addr_o = out_q.pc;
    assign out_op1_o       = out_q.op1;
    assign out_op2_o       = out_q.op2;
    assign out_reg_we_o    = out_q.reg_we;
    assign out_reg_waddr_o = out_q.rd;
    assign out_is_load_o   = out_q.is_load;
    assign out_csr_we_o    = out_q.csr_we;
    assign out_csr_addr_o  = out_q.csr_addr;
    assign out_exception_o = {29'b0, out_q.exc};
endmodule

// File: tb/tb_id_issue.sv
// Directed testbench for id_issue: reset, forwarding, load-use, backpressure, flush, system ops.
module tb_id_issue;
    localparam int XLEN = 32, RADDR_W = 5, NUM_FWD = 2;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] I_LW    = 32'h0000_A103;  // lw x2,0(x1)
    localparam logic [31:0] I_ADD   = 32'h0011_01B3;  // add x3,x2,x1
    localparam logic [31:0] RF1     = 32'h1111_1111;
    localparam logic [31:0] RF2     = 32'h2222_2222;
`ifdef ID_ILLEGAL_INST_EN
    localparam logic [31:0] ILL_EXC = 32'h4;
`else
    localparam logic [31:0] ILL_EXC = 32'h0;
`endif

    logic                       clk_i = 1'b0;
    logic                       rst_i, flush_i, in_valid_i, in_ready_o, out_ready_i;
    logic [31:0]                inst_i, out_inst_o, out_exception_o;
    logic [XLEN-1:0]            inst_addr_i, reg1_rdata_i, reg2_rdata_i;
    logic [RADDR_W-1:0]         reg1_raddr_o, reg2_raddr_o, out_reg_waddr_o;
    logic [NUM_FWD-1:0]         fwd_we_i;
    logic [NUM_FWD*RADDR_W-1:0] fwd_waddr_i;
    logic [NUM_FWD*XLEN-1:0]    fwd_wdata_i;
    logic                       out_valid_o, out_reg_we_o, out_is_load_o, out_csr_we_o;
    logic [XLEN-1:0]            out_inst_addr_o, out_op1_o, out_op2_o;
    logic [11:0]                out_csr_addr_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    id_issue dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
        .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
        .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_inst_o(out_inst_o), .out_inst_addr_o(out_inst_addr_o),
        .out_op1_o(out_op1_o), .out_op2_o(out_op2_o),
        .out_reg_we_o(out_reg_we_o), .out_reg_waddr_o(out_reg_waddr_o),
        .out_is_load_o(out_is_load_o), .out_csr_we_o(out_csr_we_o),
        .out_csr_addr_o(out_csr_addr_o), .out_exception_o(out_exception_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_fwd(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1);
        fwd_we_i    = we;
        fwd_waddr_i = {a1, a0};
        fwd_wdata_i = {d1, d0};
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        inst_i = NOP; inst_addr_i = '0; reg1_rdata_i = RF1; reg2_rdata_i = RF2;
        set_fwd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        tick();
        check("rst_valid", 32'(out_valid_o), 32'h0);
        check("rst_inst", out_inst_o, NOP);
        check("rst_exc", out_exception_o, 32'h0);

        // addi x5,x1,5 with both sources forwarding x1
        rst_i = 1'b0; in_valid_i = 1'b1; inst_i = 32'h0050_8293; inst_addr_i = 32'h100;
        set_fwd(2'b11, 5'd1, 32'hAA, 5'd1, 32'hBB);
        #1;
        check("rdy_after_rst", 32'(in_ready_o), 32'h1);
        check("raddr1", 32'(reg1_raddr_o), 32'h1);
        tick();
        check("fwd0_valid", 32'(out_valid_o), 32'h1);
        check("fwd0_op1", out_op1_o, 32'hAA);
        check("fwd0_op2", out_op2_o, 32'h5);
        check("fwd0_rd", 32'(out_reg_waddr_o), 32'h5);
        check("fwd0_we", 32'(out_reg_we_o), 32'h1);
        check("fwd0_pc", out_inst_addr_o, 32'h100);
        set_fwd(2'b10, 5'd1, 32'hAA, 5'd1, 32'hBB);
        tick();
        check("fwd1_op1", out_op1_o, 32'hBB);
        set_fwd(2'b11, 5'd2, 32'hAA, 5'd3, 32'hBB);
        tick();
        check("rf_op1", out_op1_o, RF1);
        inst_i = 32'h0050_0293;  // addi x5,x0,5; forwarding to x0 must be ignored
        set_fwd(2'b11, 5'd0, 32'hAA, 5'd0, 32'hBB);
        tick();
        check("x0_op1", out_op1_o, 32'h0);

        set_fwd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        inst_i = 32'h1234_53B7;  // lui x7,0x12345
        tick();
        check("lui_op1", out_op1_o, 32'h1234_5000);
        check("lui_op2", out_op2_o, 32'h0);
        inst_i = 32'h0000_1397; inst_addr_i = 32'h200;  // auipc x7,1
        tick();
        check("auipc_op1", out_op1_o, 32'h200);
        check("auipc_op2", out_op2_o, 32'h1000);
        inst_i = 32'h3003_D273;  // csrrwi x4,0x300,7
        tick();
        check("csri_op1", out_op1_o, 32'h7);
        check("csri_we", 32'(out_csr_we_o), 32'h1);
        check("csri_addr", 32'(out_csr_addr_o), 32'h300);
        inst_i = 32'h0020_A223;  // sw x2,4(x1)
        tick();
        check("sw_regwe", 32'(out_reg_we_o), 32'h0);
        check("sw_op2", out_op2_o, RF2);

        // load-use: two stall cycles, then add takes forwarded x2
        inst_i = I_LW; inst_addr_i = 32'h300;
        tick();
        check("lu_isload", 32'(out_is_load_o), 32'h1);
        check("lu_rd", 32'(out_reg_waddr_o), 32'h2);
        inst_i = I_ADD;
        #1;
        check("lu_stall1", 32'(in_ready_o), 32'h0);
        tick();
        check("lu_bubble", 32'(out_valid_o), 32'h0);
        check("lu_stall2", 32'(in_ready_o), 32'h0);
        tick();
        check("lu_release", 32'(in_ready_o), 32'h1);
        set_fwd(2'b01, 5'd2, 32'hCAFE, 5'd0, 32'h0);
        tick();
        check("lu_inst", out_inst_o, I_ADD);
        check("lu_op1", out_op1_o, 32'hCAFE);
        check("lu_op2", out_op2_o, RF2);
        set_fwd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

        // backpressure: counter must hold while out_ready_i=0
        inst_i = I_LW;
        tick();
        out_ready_i = 1'b0; inst_i = I_ADD;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_stall", 32'(in_ready_o), 32'h0);
            tick();
            check("bp_hold_inst", out_inst_o, I_LW);
            check("bp_hold_valid", 32'(out_valid_o), 32'h1);
        end
        out_ready_i = 1'b1;
        #1;
        check("bp_cnt_held", 32'(in_ready_o), 32'h0);
        tick();
        check("bp_cnt_1", 32'(in_ready_o), 32'h0);
        tick();
        check("bp_cnt_0", 32'(in_ready_o), 32'h1);
        tick();
        check("bp_add", out_inst_o, I_ADD);

        // flush clears output register and scoreboard
        inst_i = I_LW;
        tick();
        flush_i = 1'b1; inst_i = I_ADD;
        #1;
        check("fl_ready", 32'(in_ready_o), 32'h0);
        tick();
        flush_i = 1'b0;
        check("fl_valid", 32'(out_valid_o), 32'h0);
        check("fl_inst", out_inst_o, NOP);
        #1;
        check("fl_nostall", 32'(in_ready_o), 32'h1);
        tick();
        check("fl_add", out_inst_o, I_ADD);
        check("fl_add_valid", 32'(out_valid_o), 32'h1);

        // system instructions
        inst_i = 32'h0000_0073;
        tick();
        check("ecall_exc", out_exception_o, 32'h2);
        check("ecall_we", 32'(out_reg_we_o), 32'h0);
        inst_i = 32'h3020_0073;
        tick();
        check("mret_exc", out_exception_o, 32'h1);
        inst_i = 32'hFFFF_FFFF;
        tick();
        check("ill_exc", out_exception_o, ILL_EXC);
        check("ill_inst", out_inst_o, NOP);
        check("ill_we", 32'(out_reg_we_o), 32'h0);
        check("ill_valid", 32'(out_valid_o), 32'h1);

        // async reset mid-cycle with a load in flight
        inst_i = I_LW;
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid_o), 32'h0);
        check("arst_inst", out_inst_o, NOP);
        rst_i = 1'b0; inst_i = I_ADD;
        #1;
        check("arst_sb_clear", 32'(in_ready_o), 32'h1);
        tick();
        check("arst_add", out_inst_o, I_ADD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
